// File: rtl/pattern_gen_pkg.sv
// Shared definitions for the pattern burst generator: mode codes, FSM
// encoding and PRBS31 constants.
package pattern_gen_pkg;

    localparam logic [1:0] MODE_LANE = 2'd0;
    localparam logic [1:0] MODE_WORD = 2'd1;
    localparam logic [1:0] MODE_WALK = 2'd2;
    localparam logic [1:0] MODE_PRBS = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // PRBS31, x^31 + x^28 + 1: new bit = s[30] ^ s[27], shifted into s[0].
    localparam int              PRBS_W     = 31;
    localparam logic [PRBS_W-1:0] PRBS_SEED = 31'h7FFF_FFFF;
    localparam int              PRBS_TAP_A = 30;
    localparam int              PRBS_TAP_B = 27;

endpackage

// File: rtl/pattern_burst_generator_if.sv
// Output stream of the pattern burst generator: data word with a
// valid/ready handshake. The generator is the master, the read FIFO the slave.
interface pattern_burst_generator_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/pattern_gen_lfsr.sv
// Combinational DATA_W-step advance of the PRBS31 generator. Each step
// produces one new bit; the first-generated bit lands in data_o[0].
module pattern_gen_lfsr
    import pattern_gen_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [PRBS_W-1:0] state_i,
    output logic [PRBS_W-1:0] state_o,
    output logic [DATA_W-1:0] data_o
);

    // Unrolled shift chain: DATA_W successive shifts of the 31-bit state.
    always_comb begin
        logic [PRBS_W-1:0] s;
        logic              nb;
        s      = state_i;
        nb     = 1'b0;
        data_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            nb        = s[PRBS_TAP_A] ^ s[PRBS_TAP_B];
            data_o[i] = nb;
            s         = {s[PRBS_W-2:0], nb};
        end
        state_o = s;
    end

endmodule

// File: rtl/pattern_burst_generator.sv
// Test-data source for the host-read throughput path. Emits lane-counter,
// word-counter, walking-one or PRBS words as a finite or continuous burst.
// Optional PRBS31 mode is built only when PATTERN_GEN_PRBS_EN is defined;
// otherwise mode 3 behaves as the word counter.
module pattern_burst_generator
    import pattern_gen_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic [LEN_W-1:0]     burst_len,
    input  logic                 start,
    input  logic                 stop,
    pattern_burst_generator_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_W-1:0]     beat_count
);

    localparam int NL = DATA_W / 8;

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    logic               accept;
    logic [LEN_W-1:0]   cnt_inc;
    logic               last_beat;

    // First word of a burst for the non-PRBS patterns.
    function automatic logic [DATA_W-1:0] seed_word(input logic [1:0] m);
        logic [DATA_W-1:0] w;
        w = '0;
        case (m)
            MODE_LANE: for (int i = 0; i < NL; i++) w[8*i +: 8] = 8'(i);
            MODE_WALK: w = DATA_W'(1);
            default:   w = '0;
        endcase
        return w;
    endfunction

    // Successor word; lanes wrap independently, walking-one rotates left.
    function automatic logic [DATA_W-1:0] next_word(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] w;
        w = d + DATA_W'(1);
        case (m)
            MODE_LANE: for (int i = 0; i < NL; i++) w[8*i +: 8] = d[8*i +: 8] + 8'(NL);
            MODE_WALK: w = {d[DATA_W-2:0], d[DATA_W-1]};
            default:   ;
        endcase
        return w;
    endfunction

    assign accept    = (state_q == ST_RUN) && bus.dout_ready;
    assign cnt_inc   = cnt_q + LEN_W'(1);
    assign last_beat = (len_q != '0) && (cnt_inc == len_q);

`ifdef PATTERN_GEN_PRBS_EN
    logic [PRBS_W-1:0] prbs_q, prbs_d;
    logic [PRBS_W-1:0] lfsr_in, lfsr_state;
    logic [DATA_W-1:0] lfsr_data;

    // From IDLE the generator restarts at the seed; in RUN it continues.
    assign lfsr_in = (state_q == ST_IDLE) ? PRBS_SEED : prbs_q;

    pattern_gen_lfsr #(.DATA_W(DATA_W)) u_lfsr (
        .state_i (lfsr_in),
        .state_o (lfsr_state),
        .data_o  (lfsr_data)
    );
`endif

    // Next-state logic: burst start, beat acceptance, completion and abort.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef PATTERN_GEN_PRBS_EN
        prbs_d  = prbs_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                    len_d   = burst_len;
                    cnt_d   = '0;
                    data_d  = seed_word(mode);
`ifdef PATTERN_GEN_PRBS_EN
                    prbs_d  = lfsr_state;
                    if (mode == MODE_PRBS) data_d = lfsr_data;
`endif
                end
            end
            ST_RUN: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (last_beat) begin
                        // Final beat: dout keeps the word just delivered.
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        data_d = next_word(mode_q, data_q);
`ifdef PATTERN_GEN_PRBS_EN
                        if (mode_q == MODE_PRBS) begin
                            data_d = lfsr_data;
                            prbs_d = lfsr_state;
                        end
`endif
                    end
                end
                if (stop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_LANE;
            len_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef PATTERN_GEN_PRBS_EN
            prbs_q  <= PRBS_SEED;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef PATTERN_GEN_PRBS_EN
            prbs_q  <= prbs_d;
`endif
        end
    end

    assign bus.dout       = data_q;
    assign bus.dout_valid = (state_q == ST_RUN);
    assign busy           = (state_q == ST_RUN);
    assign done           = done_q;
    assign beat_count     = cnt_q;

endmodule

// File: doc/pattern_burst_generator.md
Name: pattern_burst_generator

Overview:
- Parametrised test-data source for the host-read throughput path.
- Produces DATA_W-bit words in one of four selectable patterns: byte-lane counter, word counter, walking-one, PRBS.
- Runs either a fixed-length burst or continuously, over a valid/ready handshake with backpressure.
- Sits between the control registers (mode, length, start/stop) and the read FIFO feeding the host interface.

Parameters:
- DATA_W, 32, output word width; multiple of 8, range 8..256.
- LEN_W, 16, width of burst length and beat counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  2  pattern select, latched at start: 0 lane counter, 1 word counter, 2 walking-one, 3 PRBS.
- burst_len  in  LEN_W  beats per burst, latched at start; 0 means continuous.
- start  in  1  one-cycle request to begin a burst.
- stop  in  1  abort the running burst.
- dout  out  DATA_W  generated word.
- dout_valid  out  1  dout holds a beat.
- dout_ready  in  1  consumer accepts the beat when dout_valid and dout_ready are both high.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when the final beat of a finite burst is accepted.
- beat_count  out  LEN_W  accepted beats since the last start; wraps modulo 2^LEN_W.

Behaviour:
- Reset: state IDLE; dout=0, dout_valid=0, busy=0, done=0, beat_count=0. Reset mid-burst aborts immediately; no done pulse.
- FSM has two states, IDLE and RUN.
- IDLE -> RUN when start=1:
  - latch mode and burst_len; seed the pattern; clear beat_count;
  - dout_valid=1 with the first beat on the next cycle (latency 1).
- In RUN, while dout_valid=1 and dout_ready=0: dout is held stable (AXI-style).
- Accept (dout_valid & dout_ready):
  - beat_count+1; dout advances to the next pattern word on the next cycle.
  - If burst_len!=0 and the accepted beat is number burst_len: -> IDLE, dout_valid=0, done=1 for one cycle. dout keeps its last value.
- stop in RUN: -> IDLE next cycle, dout_valid=0, no done. A beat accepted in the same cycle still counts.
- start while in RUN is ignored.
- start and stop together in IDLE: start wins.
- Changes to mode or burst_len after start have no effect until the next start.
- Lane counter (mode 0), with NL=DATA_W/8:
  - first beat: byte lane i = i;
  - each accept: every lane += NL, modulo 256 per lane (no carry between lanes).
- Word counter (mode 1): first beat 0; +1 per accept, modulo 2^DATA_W.
- Walking-one (mode 2): first beat 1; rotate left by 1 per accept, so bit DATA_W-1 wraps to bit 0.
- PRBS (mode 3): see Optional Feature.

Optional Feature:
- Macro: PATTERN_GEN_PRBS_EN.
- Defined:
  - mode 3 = PRBS31 (x^31+x^28+1); 31-bit state seeded to 0x7FFFFFFF at start.
  - Per shift: new bit = s[30]^s[27], shifted into s[0].
  - Each beat carries DATA_W consecutive new bits, first-generated bit in dout[0].
  - The state advances DATA_W shifts per accept.
- Undefined: no LFSR logic is synthesised; mode 3 behaves exactly as mode 1.

Decomposition:
- Package pattern_gen_pkg:
  - mode constants MODE_LANE, MODE_WORD, MODE_WALK, MODE_PRBS;
  - FSM state encoding;
  - PRBS_SEED and polynomial tap positions.
- Sub-module pattern_gen_lfsr: combinational DATA_W-step PRBS31 advance (state in, state out, data out). Instantiated only under PATTERN_GEN_PRBS_EN.

Test Plan:
- Lane count with backpressure: DATA_W=32, mode 0, burst_len 3, ready=1 -> 0x03020100, 0x07060504, 0x0B0A0908; done pulses on the 3rd accept; beat_count=3. Repeat with burst_len 65 -> beat 65 = 0x03020100 (per-lane wrap).
- Walking-one wrap: mode 2, burst_len 34 -> beat 1 = 0x00000001, beat 32 = 0x80000000, beat 33 = 0x00000001.
- Backpressure: mode 1, ready low for 5 cycles after the first valid -> dout stays 0 and beat_count stays 0. Ready high -> 0, 1, 2 in consecutive cycles.
- Continuous with stop: mode 1, burst_len 0, 1000 accepts, then stop -> dout_valid low the next cycle; no done; beat_count=1000. Also: start during RUN ignored; 0xFFFFFFFF rolls over to 0.
- Reset and restart: assert reset mid-burst -> all outputs 0 next cycle. New start -> the pattern restarts from its seed.
- PRBS: with the macro defined, mode 3 beats match a reference LFSR model for 1000 beats. With it undefined, mode 3 output equals mode 1.
